rd_slave_return: RTL and testbench

- Read-return multiplexer on the master side of the AXI interconnect.
- Forwards one of two slaves' ARREADY and R-channel signals (RLAST, RVALID, RID, RDATA, RRESP) back to a single master.
- Selection uses the per-slave master-select codes from the interconnect arbiter/decoder.
- Datapath is purely combinational. The clock and reset only drive a sticky select-conflict flag used for debug and assertions.

---
 rtl/axi_ic_pkg.sv | 28 ++
 rtl/rd_ret_gate.sv | 15 +
 rtl/rd_slave_return.sv | 95 +++++++++
 tb/tb_rd_slave_return.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ic_pkg.sv
// Shared AXI interconnect definitions: select-code encoding, default channel
// widths and the read-return bundle passed between interconnect blocks.
package axi_ic_pkg;

  localparam int SEL_W = 2;

  localparam logic [SEL_W-1:0] SEL_THIS = 2'b01;
  localparam logic [SEL_W-1:0] SEL_NONE = 2'b00;

  localparam int AXI_ID_W   = 64;
  localparam int AXI_DATA_W = 64;
  localparam int AXI_RESP_W = 2;

  typedef struct packed {
    logic                  arready;
    logic                  rlast;
    logic                  rvalid;
    logic [AXI_ID_W-1:0]   rid;
    logic [AXI_DATA_W-1:0] rdata;
    logic [AXI_RESP_W-1:0] rresp;
  } rd_ret_t;

  // Only the code 01 means the slave currently belongs to this master.
  function automatic logic sel_is_this(input logic [SEL_W-1:0] sel);
    return sel == SEL_THIS;
  endfunction

endpackage

// File: rtl/rd_ret_gate.sv
// Gates one read-return bundle with an enable so that a deselected slave
// drives all zeros into the OR stage of the return mux.
module rd_ret_gate
  import axi_ic_pkg::*;
#(
  parameter type T = rd_ret_t
) (
  input  T     bundle_in,
  input  logic en,
  output T     bundle_out
);

  assign bundle_out = bundle_in & {$bits(T){en}};

endmodule

// File: rtl/rd_slave_return.sv
// Master-side read-return mux: forwards ARREADY and the R channel of whichever
// slave this master owns, and records any cycle where both slaves claim it.
module rd_slave_return
  import axi_ic_pkg::*;
#(
  parameter int ID_W   = AXI_ID_W,
  parameter int DATA_W = AXI_DATA_W,
  parameter int RESP_W = AXI_RESP_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              s1_ARREADY,
  input  logic              s2_ARREADY,
  input  logic              s1_RLAST,
  input  logic              s2_RLAST,
  input  logic              s1_RVALID,
  input  logic              s2_RVALID,
  input  logic [ID_W-1:0]   s1_RID,
  input  logic [ID_W-1:0]   s2_RID,
  input  logic [DATA_W-1:0] s1_RDATA,
  input  logic [DATA_W-1:0] s2_RDATA,
  input  logic [RESP_W-1:0] s1_RRESP,
  input  logic [RESP_W-1:0] s2_RRESP,
  input  logic [SEL_W-1:0]  mas_sel1,
  input  logic [SEL_W-1:0]  mas_sel2,
  output logic              rd_ARREADY,
  output logic              rd_RLAST,
  output logic              rd_RVALID,
  output logic [ID_W-1:0]   rd_RID,
  output logic [DATA_W-1:0] rd_RDATA,
  output logic [RESP_W-1:0] rd_RRESP,
  output logic              rd_sel_conflict
);

  // Local bundle type so width overrides on this instance stay consistent.
  typedef struct packed {
    logic              arready;
    logic              rlast;
    logic              rvalid;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [RESP_W-1:0] rresp;
  } ret_t;

  logic s1_hit;
  logic s2_hit;
  logic en1;
  logic en2;
  ret_t s1_ret;
  ret_t s2_ret;
  ret_t s1_gated;
  ret_t s2_gated;
  ret_t rd_ret;

  assign s1_hit = sel_is_this(mas_sel1);
  assign s2_hit = sel_is_this(mas_sel2);

  // Slave 1 wins a double hit; enables stay one-hot so nothing leaks through.
  assign en1 = s1_hit;
  assign en2 = s2_hit & ~s1_hit;

  assign s1_ret = {s1_ARREADY, s1_RLAST, s1_RVALID, s1_RID, s1_RDATA, s1_RRESP};
  assign s2_ret = {s2_ARREADY, s2_RLAST, s2_RVALID, s2_RID, s2_RDATA, s2_RRESP};

  rd_ret_gate #(.T(ret_t)) u_gate_s1 (
    .bundle_in  (s1_ret),
    .en         (en1),
    .bundle_out (s1_gated)
  );

  rd_ret_gate #(.T(ret_t)) u_gate_s2 (
    .bundle_in  (s2_ret),
    .en         (en2),
    .bundle_out (s2_gated)
  );

  assign rd_ret = s1_gated | s2_gated;

  assign rd_ARREADY = rd_ret.arready;
  assign rd_RLAST   = rd_ret.rlast;
  assign rd_RVALID  = rd_ret.rvalid;
  assign rd_RID     = rd_ret.rid;
  assign rd_RDATA   = rd_ret.rdata;
  assign rd_RRESP   = rd_ret.rresp;

  // Sticky debug flag; only reset clears it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_sel_conflict <= 1'b0;
    end else if (s1_hit && s2_hit) begin
      rd_sel_conflict <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rd_slave_return.sv
// Directed self-checking bench for rd_slave_return: decode paths, fixed
// priority on double hits, sticky conflict flag and reset transparency.
module tb_rd_slave_return;

  localparam int ID_W   = 64;
  localparam int DATA_W = 64;
  localparam int RESP_W = 2;
  localparam int VEC_W  = 3 + ID_W + DATA_W + RESP_W;

  logic              i_clk;
  logic              i_rst;
  logic [1:0]        mas_sel1;
  logic [1:0]        mas_sel2;
  logic [VEC_W-1:0]  s1_vec;
  logic [VEC_W-1:0]  s2_vec;

  logic              rd_ARREADY;
  logic              rd_RLAST;
  logic              rd_RVALID;
  logic [ID_W-1:0]   rd_RID;
  logic [DATA_W-1:0] rd_RDATA;
  logic [RESP_W-1:0] rd_RRESP;
  logic              rd_sel_conflict;
  logic [VEC_W-1:0]  rd_vec;

  int pass_cnt;
  int total_cnt;

  assign rd_vec = {rd_ARREADY, rd_RLAST, rd_RVALID, rd_RID, rd_RDATA, rd_RRESP};

  rd_slave_return dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .s1_ARREADY      (s1_vec[VEC_W-1]),
    .s2_ARREADY      (s2_vec[VEC_W-1]),
    .s1_RLAST        (s1_vec[VEC_W-2]),
    .s2_RLAST        (s2_vec[VEC_W-2]),
    .s1_RVALID       (s1_vec[VEC_W-3]),
    .s2_RVALID       (s2_vec[VEC_W-3]),
    .s1_RID          (s1_vec[VEC_W-4 -: ID_W]),
    .s2_RID          (s2_vec[VEC_W-4 -: ID_W]),
    .s1_RDATA        (s1_vec[RESP_W +: DATA_W]),
    .s2_RDATA        (s2_vec[RESP_W +: DATA_W]),
    .s1_RRESP        (s1_vec[RESP_W-1:0]),
    .s2_RRESP        (s2_vec[RESP_W-1:0]),
    .mas_sel1        (mas_sel1),
    .mas_sel2        (mas_sel2),
    .rd_ARREADY      (rd_ARREADY),
    .rd_RLAST        (rd_RLAST),
    .rd_RVALID       (rd_RVALID),
    .rd_RID          (rd_RID),
    .rd_RDATA        (rd_RDATA),
    .rd_RRESP        (rd_RRESP),
    .rd_sel_conflict (rd_sel_conflict)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference decode: slave 1 first, then slave 2, else all zeros.
  function automatic logic [VEC_W-1:0] model(input logic [1:0] sel1, input logic [1:0] sel2,
                                             input logic [VEC_W-1:0] v1, input logic [VEC_W-1:0] v2);
    if (sel1 == 2'b01) return v1;
    if (sel2 == 2'b01) return v2;
    return '0;
  endfunction

  task automatic test_reset();
    i_rst = 1'b1;
    mas_sel1 = 2'b00;
    mas_sel2 = 2'b00;
    s1_vec = '0;
    s2_vec = '0;
    @(posedge i_clk); #1;
    total_cnt++;
    if (rd_sel_conflict !== 1'b0) $display("[TB] FAIL reset_conflict: got %b expected 0", rd_sel_conflict);
    else pass_cnt++;
    total_cnt++;
    if (rd_vec !== '0) $display("[TB] FAIL reset_outputs: got %h expected 0", rd_vec);
    else pass_cnt++;
    i_rst = 1'b0;
  endtask

  task automatic test_slave1();
    @(posedge i_clk); #2;
    s1_vec = '0;
    s2_vec = '1;
    mas_sel1 = 2'b01;
    mas_sel2 = 2'b10;
    #1;
    total_cnt++;
    if (rd_vec !== '0) $display("[TB] FAIL slave1_path: got %h expected 0", rd_vec);
    else pass_cnt++;
  endtask

  task automatic test_slave2();
    logic [VEC_W-1:0] exp;
    @(posedge i_clk); #2;
    s1_vec = '1;
    s2_vec = {1'b1, 1'b1, 1'b1, 64'd1, 64'd1, 2'b01};
    mas_sel1 = 2'b10;
    mas_sel2 = 2'b01;
    exp = {1'b1, 1'b1, 1'b1, 64'd1, 64'd1, 2'b01};
    #1;
    total_cnt++;
    if (rd_vec !== exp) $display("[TB] FAIL slave2_path: got %h expected %h", rd_vec, exp);
    else pass_cnt++;
    total_cnt++;
    if (rd_RRESP !== 2'b01) $display("[TB] FAIL slave2_rresp: got %b expected 01", rd_RRESP);
    else pass_cnt++;
  endtask

  task automatic test_none();
    @(posedge i_clk); #2;
    s1_vec = '1;
    s2_vec = '1;
    mas_sel1 = 2'b00;
    mas_sel2 = 2'b11;
    #1;
    total_cnt++;
    if (rd_vec !== '0) $display("[TB] FAIL none_00_11: got %h expected 0", rd_vec);
    else pass_cnt++;
    mas_sel1 = 2'b11;
    mas_sel2 = 2'b00;
    #1;
    total_cnt++;
    if (rd_vec !== '0) $display("[TB] FAIL none_11_00: got %h expected 0", rd_vec);
    else pass_cnt++;
    mas_sel1 = 2'b10;
    mas_sel2 = 2'b10;
    #1;
    total_cnt++;
    if (rd_vec !== '0) $display("[TB] FAIL none_10_10: got %h expected 0", rd_vec);
    else pass_cnt++;
  endtask

  task automatic test_random_sel();
    logic [VEC_W-1:0] exp;
    for (int i = 0; i < 16; i++) begin
      @(posedge i_clk); #2;
      mas_sel1 = 2'($urandom_range(0, 3));
      mas_sel2 = ~mas_sel1;
      s1_vec = {$urandom, $urandom, $urandom, $urandom, $urandom};
      s2_vec = {$urandom, $urandom, $urandom, $urandom, $urandom};
      exp = model(mas_sel1, mas_sel2, s1_vec, s2_vec);
      #1;
      total_cnt++;
      if (rd_vec !== exp)
        $display("[TB] FAIL random_sel[%0d] sel=%b/%b: got %h expected %h", i, mas_sel1, mas_sel2, rd_vec, exp);
      else pass_cnt++;
    end
    @(posedge i_clk); #1;
    total_cnt++;
    if (rd_sel_conflict !== 1'b0) $display("[TB] FAIL no_false_conflict: got %b expected 0", rd_sel_conflict);
    else pass_cnt++;
  endtask

  task automatic test_conflict();
    @(posedge i_clk); #2;
    s1_vec = {1'b1, 1'b0, 1'b1, 64'h11, {8{8'hAA}}, 2'b10};
    s2_vec = {1'b0, 1'b1, 1'b0, 64'h22, {8{8'h55}}, 2'b11};
    mas_sel1 = 2'b01;
    mas_sel2 = 2'b01;
    #1;
    total_cnt++;
    if (rd_vec !== {1'b1, 1'b0, 1'b1, 64'h11, {8{8'hAA}}, 2'b10})
      $display("[TB] FAIL conflict_priority: got %h expected slave1 bundle", rd_vec);
    else pass_cnt++;
    total_cnt++;
    if (rd_sel_conflict !== 1'b0) $display("[TB] FAIL conflict_before_edge: got %b expected 0", rd_sel_conflict);
    else pass_cnt++;
    @(posedge i_clk); #1;
    total_cnt++;
    if (rd_sel_conflict !== 1'b1) $display("[TB] FAIL conflict_set: got %b expected 1", rd_sel_conflict);
    else pass_cnt++;
    mas_sel2 = 2'b00;
    repeat (2) @(posedge i_clk);
    #1;
    total_cnt++;
    if (rd_sel_conflict !== 1'b1) $display("[TB] FAIL conflict_sticky: got %b expected 1", rd_sel_conflict);
    else pass_cnt++;
  endtask

  task automatic test_reset_clears();
    @(posedge i_clk); #2;
    mas_sel1 = 2'b10;
    mas_sel2 = 2'b01;
    s2_vec = {1'b1, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 2'b10};
    i_rst = 1'b1;
    #1;
    total_cnt++;
    if (rd_vec !== s2_vec) $display("[TB] FAIL reset_forward_pre: got %h expected %h", rd_vec, s2_vec);
    else pass_cnt++;
    @(posedge i_clk); #1;
    total_cnt++;
    if (rd_sel_conflict !== 1'b0) $display("[TB] FAIL reset_clears_conflict: got %b expected 0", rd_sel_conflict);
    else pass_cnt++;
    total_cnt++;
    if (rd_vec !== s2_vec) $display("[TB] FAIL reset_forward_post: got %h expected %h", rd_vec, s2_vec);
    else pass_cnt++;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    total_cnt++;
    if (rd_sel_conflict !== 1'b0) $display("[TB] FAIL conflict_after_reset: got %b expected 0", rd_sel_conflict);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_slave1();
    test_slave2();
    test_none();
    test_random_sel();
    test_conflict();
    test_reset_clears();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
